// File: rtl/afifo_sync_fifo.sv
// Single-clock FIFO core with fill count, almost-full/almost-empty thresholds,
// sticky overflow/underflow flags, synchronous flush and a selectable
// registered or first-word-fall-through read port.
module afifo_sync_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned AF_THRESH  = (2 ** ADDR_WIDTH) - 4,
    parameter int unsigned AE_THRESH  = 4,
    parameter bit          FWFT       = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  winc,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  wfull,
    input  logic                  rinc,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rempty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  almost_full,
    output logic                  almost_empty,
    input  logic                  flush,
    input  logic                  clr_err,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned         DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ONE       = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH:0]   wptr;
    logic [ADDR_WIDTH:0]   rptr;
    logic [ADDR_WIDTH:0]   count_nxt;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [ADDR_WIDTH-1:0] raddr;
    logic                  wr_ok;
    logic                  rd_ok;
    logic                  ovf_evt;
    logic                  unf_evt;

    assign waddr = wptr[ADDR_WIDTH-1:0];
    assign raddr = rptr[ADDR_WIDTH-1:0];

    // Status flags are decoded from the registered count only, so there is
    // no combinational path from winc/rinc to any flag.
    assign wfull        = (count == DEPTH_CNT);
    assign rempty       = (count == '0);
    assign almost_full  = (32'(count) >= AF_THRESH);
    assign almost_empty = (32'(count) <= AE_THRESH);

    // Accept/reject decisions and error events; flush swallows both requests.
    always_comb begin
        wr_ok   = winc && !wfull  && !flush;
        rd_ok   = rinc && !rempty && !flush;
        ovf_evt = winc &&  wfull  && !flush;
        unf_evt = rinc &&  rempty && !flush;
    end

    // Occupancy update: +1 on write only, -1 on read only, else unchanged.
    always_comb begin
        count_nxt = count;
        unique case ({wr_ok, rd_ok})
            2'b10:   count_nxt = count + ONE;
            2'b01:   count_nxt = count - ONE;
            default: count_nxt = count;
        endcase
    end

    // Storage array; deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[waddr] <= wdata;
        end
    end

    // Pointers and occupancy; flush clears them synchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + ONE;
            end
            if (rd_ok) begin
                rptr <= rptr + ONE;
            end
            count <= count_nxt;
        end
    end

    // Sticky error flags; a new event in the same cycle as clr_err wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (overflow  && !clr_err) || ovf_evt;
            underflow <= (underflow && !clr_err) || unf_evt;
        end
    end

    generate
        if (FWFT) begin : g_fwft
            // Head word presented combinationally; forced to zero while empty.
            always_comb begin
                rdata = rempty ? '0 : mem[raddr];
            end
        end else begin : g_std
            logic [DATA_WIDTH-1:0] rdata_q;

            // Registered read: capture the head word on an accepted pop, hold otherwise.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rdata_q <= '0;
                end else if (rd_ok) begin
                    rdata_q <= mem[raddr];
                end
            end

            assign rdata = rdata_q;
        end
    endgenerate

    // Pointer distance (modulo 2*DEPTH) must always equal the occupancy register.
    a_ptr_count: assert property (@(posedge clk) disable iff (!rst_n) (wptr - rptr) == count);

endmodule
